// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V core front end.
// Holds the data width, the canonical NOP encoding, the sequential PC
// step, the fetch-unit state encoding and a PC alignment helper.
package rv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

   typedef enum logic {
      ST_RUN,
      ST_DRAIN
   } fetch_state_e;

   // Instructions are word aligned; the low two address bits are forced to zero.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO that buffers fetched {pc, inst} pairs.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   flush           empties the FIFO at the next edge (wins over push/pop)
//   push, push_data write one entry
//   pop             remove the head entry
//   head            current head entry (valid when !empty)
//   count           number of stored entries (0..DEPTH)
//   full, empty     occupancy flags
module inst_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop && !flush));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/gnt requests to
// instruction memory, buffers in-order responses and presents {pc, inst}
// to decode. EX-stage redirects flush the buffer and discard responses of
// requests that were already in flight.
// Ports:
//   clk, rst_n                    clock and synchronous active-low reset
//   imem_req/addr/gnt             request channel (handshake = req && gnt)
//   imem_rvalid/rdata             in-order response channel
//   redirect_valid/redirect_pc    control-flow change from EX
//   id_ready                      decode accepts the current output
//   if_valid/if_inst/if_pc        instruction presented to decode
module inst_fetch_unit
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            if_valid,
   output logic [XLEN-1:0] if_inst,
   output logic [XLEN-1:0] if_pc
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

   fetch_state_e       state;
   logic               rst_seen;
   logic [XLEN-1:0]    pc;
   logic [XLEN-1:0]    resp_pc;
   logic [CW-1:0]      outstanding;
   logic [CW-1:0]      outstanding_next;
   logic [CW-1:0]      drop_cnt;
   logic [CW-1:0]      fifo_count;
   logic [CW:0]        credits_used;
   logic               handshake;
   logic               draining;
   logic               keep_resp;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [2*XLEN-1:0]  head;

   // Every in-flight request must have a guaranteed FIFO slot, so requests
   // are throttled on outstanding + buffered entries.
   assign credits_used     = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req         = rst_seen && !redirect_valid && (credits_used < DEPTH_LIM);
   assign imem_addr        = pc;
   assign handshake        = imem_req && imem_gnt;
   assign outstanding_next = outstanding + CW'(handshake) - CW'(imem_rvalid);

   assign draining  = (state == ST_DRAIN);
   assign keep_resp = imem_rvalid && !draining && !redirect_valid;
   assign pop       = if_valid && id_ready;
   assign push      = keep_resp && (!fifo_full || pop);

   assign if_valid = !fifo_empty;
   assign if_inst  = if_valid ? head[XLEN-1:0]      : NOP_INST;
   assign if_pc    = if_valid ? head[2*XLEN-1:XLEN] : '0;

   // Drop tracking: a redirect snapshots the outstanding count after this
   // cycle's grant/response, so every older response is discarded in order.
   // Back-to-back redirects simply overwrite the snapshot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         drop_cnt <= outstanding_next;
         state    <= (outstanding_next != '0) ? ST_DRAIN : ST_RUN;
      end else if (draining && imem_rvalid) begin
         drop_cnt <= drop_cnt - CW'(1);
         if (drop_cnt == CW'(1)) state <= ST_RUN;
      end
   end

   // PC and response tag tracking. resp_pc is the address of the next
   // response that will be kept, so it only advances on accepted words.
   // rst_seen delays the first request by one cycle after reset release.
   always_ff @(posedge clk) begin
      rst_seen <= rst_n;
      if (!rst_n) begin
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            pc      <= align_pc(redirect_pc);
            resp_pc <= align_pc(redirect_pc);
         end else begin
            if (handshake) pc      <= pc + PC_STEP;
            if (push)      resp_pc <= resp_pc + PC_STEP;
         end
      end
   end

   inst_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({resp_pc, imem_rdata}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
